aes_key_schedule: RTL and testbench

AES_KEY_SCHEDULE -- requirements
Module: aes_key_schedule

---
 rtl/aes_pkg.sv | 24 ++
 rtl/aes_sbox.sv | 42 ++++
 rtl/aes_key_schedule.sv | 138 +++++++++++++
 tb/tb_aes_key_schedule.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES key schedule: FSM states, the Rcon table,
// the round-count derivation and the key-size legality check.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } ks_state_e;

  // Round constants, MSB byte of the word. AES-256 only uses the first 7.
  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic bit key_bits_legal(input int key_bits);
    return (key_bits == 128) || (key_bits == 256);
  endfunction

  function automatic int nr_of(input int key_bits);
    return (key_bits == 256) ? 14 : 10;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box for one byte: multiplicative inverse in GF(2^8)
// followed by the affine transform. Purely combinational.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 = x^-1 for x != 0, and 0 maps to 0 naturally.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] res;
    logic [7:0] sq;
    res = 8'h01;
    sq  = x;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      res = gf_mul(res, sq);
    end
    return res;
  endfunction

  logic [7:0] inv;

  // Inverse then affine map.
  always_comb begin
    inv      = gf_inv(in_byte);
    out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_schedule.sv
// AES key expansion engine with a registered round-key read port.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   ST_IDLE   | no schedule held (after reset); waiting for fsm_en
//   ST_EXPAND | one round key written per cycle, busy=1
//   ST_DONE   | full schedule stored, keys_ready=1; fsm_en restarts
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] KEY,
  input  logic         fsm_en,
  input  logic         dec_order,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out,
  output logic         rk_valid,
  output logic         keys_ready,
  output logic         busy
);

  localparam int         NR        = nr_of(KEY_BITS);
  localparam logic [3:0] NR_L      = 4'(NR);
  localparam logic [3:0] FIRST_RND = (KEY_BITS == 256) ? 4'd2 : 4'd1;

  if (!key_bits_legal(KEY_BITS)) begin : g_bad_key_bits
    $error("aes_key_schedule: KEY_BITS must be 128 or 256");
  end

  ks_state_e state_q, state_d;
  logic [3:0]          round_q, round_d;
  // Sliding window of the latest key material: last round key (128) or the
  // last two round keys (256), seeded with the latched cipher key.
  logic [KEY_BITS-1:0] win_q, win_d, win_next;
  logic [127:0]        rk_q [NR+1];
  logic [127:0]        rk_d [NR+1];
  logic [127:0]        rk_out_q, rk_out_d;
  logic                rk_valid_q, rk_valid_d;

  logic [127:0] prev_blk, new_blk;
  logic [31:0]  w_last, sub_in, sub_out, temp;
  logic [3:0]   rcon_idx, rd_idx;
  logic [7:0]   rcon_b;
  logic         use_rot;
  logic         unused_key;

  assign unused_key = ^KEY[127:0];

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (sub_in[8*b +: 8]),
      .out_byte (sub_out[8*b +: 8])
    );
  end

  // Next round key from the window; odd AES-256 rounds skip RotWord/Rcon.
  always_comb begin
    prev_blk = win_q[KEY_BITS-1 -: 128];
    w_last   = win_q[31:0];
    use_rot  = (KEY_BITS == 128) || !round_q[0];
    rcon_idx = (KEY_BITS == 256) ? ({1'b0, round_q[3:1]} - 4'd1) : (round_q - 4'd1);
    rcon_b   = (rcon_idx < 4'd10) ? RCON[rcon_idx] : 8'h00;
    sub_in   = use_rot ? {w_last[23:0], w_last[31:24]} : w_last;
    temp     = sub_out ^ (use_rot ? {rcon_b, 24'h0} : 32'h0);
    new_blk[127:96] = prev_blk[127:96] ^ temp;
    new_blk[95:64]  = prev_blk[95:64]  ^ new_blk[127:96];
    new_blk[63:32]  = prev_blk[63:32]  ^ new_blk[95:64];
    new_blk[31:0]   = prev_blk[31:0]   ^ new_blk[63:32];
  end

  if (KEY_BITS == 256) begin : g_win256
    assign win_next = {win_q[127:0], new_blk};
  end else begin : g_win128
    assign win_next = new_blk;
  end

  // Sequencing: accept in IDLE/DONE, one round per cycle in EXPAND.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    win_d   = win_q;
    rk_d    = rk_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (fsm_en) begin
          win_d   = KEY[255 -: KEY_BITS];
          rk_d[0] = KEY[255:128];
          if (KEY_BITS == 256) rk_d[1] = KEY[127:0];
          round_d = FIRST_RND;
          state_d = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        rk_d[round_q] = new_blk;
        win_d         = win_next;
        round_d       = round_q + 4'd1;
        if (round_q == NR_L) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read port: reverse mapping for decryption, zero beyond the last round.
  always_comb begin
    rd_idx     = dec_order ? (NR_L - rk_idx) : rk_idx;
    rk_out_d   = '0;
    if (rk_idx <= NR_L) rk_out_d = rk_q[rd_idx];
    rk_valid_d = keys_ready;
  end

  // State, schedule storage and read registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      round_q    <= '0;
      win_q      <= '0;
      rk_q       <= '{default: '0};
      rk_out_q   <= '0;
      rk_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      round_q    <= round_d;
      win_q      <= win_d;
      rk_q       <= rk_d;
      rk_out_q   <= rk_out_d;
      rk_valid_q <= rk_valid_d;
    end
  end

  assign busy       = (state_q == ST_EXPAND);
  assign keys_ready = (state_q == ST_DONE);
  assign rk_out     = rk_out_q;
  assign rk_valid   = rk_valid_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Bench for aes_key_schedule: AES-128 and AES-256 instances share stimulus
// and are each compared every cycle against a FIPS-197 style model.
module tb_aes_key_schedule;

  localparam logic [255:0] KEY_A =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] key_in = '0;
  logic         fsm_en = 1'b0;
  logic         dec_order = 1'b0;
  logic [3:0]   rk_idx = '0;

  logic [127:0] rk_out_w     [2];
  logic         rk_valid_w   [2];
  logic         keys_ready_w [2];
  logic         busy_w       [2];

  int  vectors = 0;
  int  miscompares = 0;
  bit  chk_on = 1'b0;
  logic [7:0] sbox_t [256];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: dut=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    while (y != 8'h00) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box built by brute-force inverse search plus the bitwise affine rule.
  initial begin
    logic [7:0] inv, s;
    logic [7:0] aff_c;
    aff_c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ aff_c[i];
      sbox_t[x] = s;
    end
  end

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  // Textbook word-oriented key expansion; round r at bits [r*128 +: 128].
  function automatic logic [15*128-1:0] expand(input logic [255:0] key, input int kb);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    logic [15*128-1:0] res = '0;
    int nk = kb / 32;
    int nr = (kb == 128) ? 10 : 14;
    for (int j = 0; j < nk; j++) w[j] = key[255-32*j -: 32];
    for (int j = nk; j < 4*(nr+1); j++) begin
      t = w[j-1];
      if (j % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (nk > 6 && j % nk == 4) begin
        t = sub_word(t);
      end
      w[j] = w[j-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) res[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return res;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int KB = (g == 0) ? 128 : 256;
    localparam int NR = (g == 0) ? 10 : 14;

    logic [127:0]      m_store [15];
    logic [15*128-1:0] m_sched = '0;
    logic [127:0]      m_out = '0;
    bit                m_busy = 1'b0;
    bit                m_ready = 1'b0;
    bit                m_valid = 1'b0;
    int                m_cnt = 0;
    int                m_r = 0;

    aes_key_schedule #(.KEY_BITS(KB)) dut (
      .clk        (clk),
      .rst        (rst),
      .KEY        (key_in),
      .fsm_en     (fsm_en),
      .dec_order  (dec_order),
      .rk_idx     (rk_idx),
      .rk_out     (rk_out_w[g]),
      .rk_valid   (rk_valid_w[g]),
      .keys_ready (keys_ready_w[g]),
      .busy       (busy_w[g])
    );

    // Model: reads see the pre-edge store; round r lands r edges after accept
    // (r-1 edges for AES-256, whose first two rounds come from the key).
    always @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < 15; i++) m_store[i] = '0;
        m_busy = 1'b0; m_ready = 1'b0; m_valid = 1'b0; m_out = '0; m_cnt = 0;
      end else begin
        m_valid = m_ready;
        if (int'(rk_idx) > NR) m_out = '0;
        else m_out = m_store[dec_order ? NR - int'(rk_idx) : int'(rk_idx)];
        if (m_busy) begin
          m_cnt++;
          m_r = (KB == 128) ? m_cnt : m_cnt + 1;
          m_store[m_r] = m_sched[m_r*128 +: 128];
          if (m_r == NR) begin
            m_busy  = 1'b0;
            m_ready = 1'b1;
          end
        end else if (fsm_en) begin
          m_sched = expand(key_in, KB);
          m_store[0] = m_sched[127:0];
          if (KB == 256) m_store[1] = m_sched[255:128];
          m_cnt   = 0;
          m_busy  = 1'b1;
          m_ready = 1'b0;
        end
      end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
      if (chk_on) begin
        check($sformatf("busy_%0d", KB),       128'(busy_w[g]),       128'(m_busy));
        check($sformatf("keys_ready_%0d", KB), 128'(keys_ready_w[g]), 128'(m_ready));
        check($sformatf("rk_valid_%0d", KB),   128'(rk_valid_w[g]),   128'(m_valid));
        check($sformatf("rk_out_%0d", KB),     rk_out_w[g],           m_out);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic dec, input logic [3:0] idx);
    dec_order = dec;
    rk_idx    = idx;
    tick();
  endtask

  // Pulse fsm_en, then count edges until keys_ready; optionally disturb
  // with a second request and a new KEY four cycles into expansion.
  task automatic start_and_wait(input string tag, input bit disturb);
    int n128, n256;
    fsm_en = 1'b1;
    tick();
    fsm_en = 1'b0;
    n128 = 0;
    n256 = 0;
    for (int n = 1; n <= 30 && (n128 == 0 || n256 == 0); n++) begin
      tick();
      fsm_en = 1'b0;
      if (disturb && n == 4) begin
        fsm_en = 1'b1;
        key_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end
      if (keys_ready_w[0] && n128 == 0) n128 = n;
      if (keys_ready_w[1] && n256 == 0) n256 = n;
    end
    fsm_en = 1'b0;
    check({tag, "_edges128"}, 128'(n128), 128'd10);
    check({tag, "_edges256"}, 128'(n256), 128'd13);
  endtask

  initial begin
    logic [15*128-1:0] sched;

    #1 rst = 1'b0;
    check("sbox_00", 128'(sbox_t[8'h00]), 128'h63);
    check("sbox_53", 128'(sbox_t[8'h53]), 128'hed);
    sched = expand(KEY_A, 128);
    check("model128_r1",  sched[1*128 +: 128],  128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    check("model128_r10", sched[10*128 +: 128], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    sched = expand(KEY_A, 256);
    check("model256_r14", sched[14*128 +: 128], 128'h24fc79ccbf0979e9371ac23c6d68de36);

    repeat (3) @(posedge clk);
    #1;
    chk_on = 1'b1;
    check("reset_rk_out", rk_out_w[0], 128'h0);
    check("reset_busy",   128'(busy_w[1]), 128'h0);
    check("reset_ready",  128'(keys_ready_w[0]), 128'h0);

    // First accept on the very edge reset is released.
    key_in = KEY_A;
    rst    = 1'b1;
    start_and_wait("basic", 1'b0);
    rd(1'b0, 4'd1);
    check("r1_128", rk_out_w[0], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    check("r1_256", rk_out_w[1], 128'h101112131415161718191a1b1c1d1e1f);
    check("r1_valid", 128'(rk_valid_w[0]), 128'h1);
    rd(1'b0, 4'd10);
    check("r10_128", rk_out_w[0], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    rd(1'b0, 4'd14);
    check("r14_256", rk_out_w[1], 128'h24fc79ccbf0979e9371ac23c6d68de36);
    check("r14_128_zero", rk_out_w[0], 128'h0);
    rd(1'b0, 4'd15);
    check("r15_128_zero",  rk_out_w[0], 128'h0);
    check("r15_128_valid", 128'(rk_valid_w[0]), 128'h1);
    rd(1'b1, 4'd0);
    check("dec0_128", rk_out_w[0], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    check("dec0_256", rk_out_w[1], 128'h24fc79ccbf0979e9371ac23c6d68de36);
    rd(1'b1, 4'd10);
    check("dec10_128", rk_out_w[0], 128'h000102030405060708090a0b0c0d0e0f);

    // Second request and KEY change mid-expansion are ignored.
    key_in = KEY_A;
    start_and_wait("ignore", 1'b1);
    rd(1'b0, 4'd1);
    check("ign_r1_128", rk_out_w[0], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    rd(1'b0, 4'd10);
    check("ign_r10_128", rk_out_w[0], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // Reset in the 5th expansion cycle, then restart.
    key_in = KEY_A;
    fsm_en = 1'b1;
    tick();
    fsm_en = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    #1;
    check("abort_busy",  128'(busy_w[0]), 128'h0);
    check("abort_ready", 128'(keys_ready_w[1]), 128'h0);
    check("abort_rk",    rk_out_w[0], 128'h0);
    check("abort_valid", 128'(rk_valid_w[1]), 128'h0);
    tick();
    rst = 1'b1;
    start_and_wait("restart", 1'b0);
    rd(1'b0, 4'd1);
    check("rst_r1_128", rk_out_w[0], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    rd(1'b0, 4'd10);
    check("rst_r10_128", rk_out_w[0], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      fsm_en    = ($urandom_range(0, 9) == 0);
      dec_order = 1'($urandom);
      rk_idx    = 4'($urandom_range(0, 15));
      key_in    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rst       = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    rst = 1'b1;
    repeat (2) tick();

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
